// File: rtl/mem_port_arbiter.sv
// Arbitrates the single CPU memory port between instruction fetch and the load/store unit,
// one transaction at a time, with a bounded data-run fairness rule and an access timeout.
module mem_port_arbiter #(
    parameter int unsigned WORD_SIZE      = 16,
    parameter int unsigned MAX_DATA_RUN   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic [WORD_SIZE-1:0] i_rdata,
    output logic                 i_done,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_done,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    input  logic                 inputReady,
    input  logic                 ackOutput,
    output logic                 err
);

    localparam int unsigned RUN_W   = $clog2(MAX_DATA_RUN + 1);
    localparam int unsigned TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned TO_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        RELEASE
    } state_t;

    state_t               state;
    logic                 owner_data;
    logic [WORD_SIZE-1:0] wdata;
    logic                 data_oe;
    logic [RUN_W-1:0]     run_cnt;
    logic [TO_W-1:0]      tcnt;

    logic run_full;
    logic data_wins;
    logic timeout_hit;

    assign run_full    = (run_cnt == RUN_W'(MAX_DATA_RUN));
    assign data_wins   = d_req && !(i_req && run_full);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (tcnt == TO_W'(TO_LAST));

    // Bus is driven only while a write is on the port; the enable is a flop.
    assign data = data_oe ? wdata : {WORD_SIZE{1'bz}};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner_data <= 1'b0;
            wdata      <= '0;
            data_oe    <= 1'b0;
            run_cnt    <= '0;
            tcnt       <= '0;
            readM      <= 1'b0;
            writeM     <= 1'b0;
            address    <= '0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            i_done     <= 1'b0;
            d_done     <= 1'b0;
            err        <= 1'b0;
        end else begin
            i_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state)
                IDLE: begin
                    tcnt <= '0;
                    if (data_wins) begin
                        owner_data <= 1'b1;
                        address    <= d_addr;
                        wdata      <= d_wdata;
                        // Count data grants only while fetch is actually waiting.
                        if (!i_req)
                            run_cnt <= '0;
                        else if (!run_full)
                            run_cnt <= run_cnt + RUN_W'(1);
                        if (d_we) begin
                            writeM  <= 1'b1;
                            data_oe <= 1'b1;
                            state   <= WRITE;
                        end else begin
                            readM <= 1'b1;
                            state <= READ;
                        end
                    end else if (i_req) begin
                        owner_data <= 1'b0;
                        address    <= i_addr;
                        run_cnt    <= '0;
                        readM      <= 1'b1;
                        state      <= READ;
                    end
                end
                READ: begin
                    if (inputReady || timeout_hit) begin
                        readM <= 1'b0;
                        state <= RELEASE;
                        err   <= !inputReady;
                        if (owner_data) begin
                            d_rdata <= inputReady ? data : '0;
                            d_done  <= 1'b1;
                        end else begin
                            i_rdata <= inputReady ? data : '0;
                            i_done  <= 1'b1;
                        end
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                WRITE: begin
                    if (ackOutput || timeout_hit) begin
                        writeM  <= 1'b0;
                        data_oe <= 1'b0;
                        d_done  <= 1'b1;
                        err     <= !ackOutput;
                        state   <= RELEASE;
                    end else begin
                        tcnt <= tcnt + TO_W'(1);
                    end
                end
                RELEASE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a behavioural memory answers strobes and every
// completion is matched in order against the accesses the bench expects to be granted.
module tb_mem_port_arbiter;

    typedef struct packed {
        logic        is_data;
        logic        is_read;
        logic [15:0] addr;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic [15:0] i_rdata, d_rdata, address;
    logic        i_done, d_done, readM, writeM, err;
    logic        inputReady, ackOutput;
    wire  [15:0] data;

    logic [15:0] mem [0:63];
    logic [15:0] mem_q;
    logic        mem_drive;
    logic        mem_hang;
    int          lat;
    int          wait_cnt;
    logic        tb_drive;
    logic [15:0] tb_val;

    exp_t        sb[$];
    logic [15:0] last_addr;
    int          n_checks = 0;
    int          n_errors = 0;

    assign data = mem_drive ? mem_q : (tb_drive ? tb_val : 16'hzzzz);

    mem_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_rdata    (i_rdata),
        .i_done     (i_done),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_rdata    (d_rdata),
        .d_done     (d_done),
        .readM      (readM),
        .writeM     (writeM),
        .address    (address),
        .data       (data),
        .inputReady (inputReady),
        .ackOutput  (ackOutput),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory model: answers a strobe after lat idle cycles unless hung.
    always @(negedge clk) begin
        inputReady = 1'b0;
        ackOutput  = 1'b0;
        mem_drive  = 1'b0;
        if (readM && !mem_hang) begin
            if (wait_cnt >= lat) begin
                inputReady = 1'b1;
                mem_drive  = 1'b1;
                mem_q      = mem[address[5:0]];
            end else begin
                wait_cnt++;
            end
        end else if (writeM && !mem_hang) begin
            if (wait_cnt >= lat) begin
                ackOutput          = 1'b1;
                mem[address[5:0]] = data;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Completion monitor: pops the next expected access and compares it.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (readM || writeM)
            last_addr = address;
        if (i_done || d_done) begin
            check_eq("done_onehot", {15'd0, i_done & d_done}, 16'd0);
            if (sb.size() == 0) begin
                check_eq("unexpected_done", 16'd1, {15'd0, sb.size() != 0});
            end else begin
                e = sb.pop_front();
                check_eq("owner", {15'd0, d_done}, {15'd0, e.is_data});
                check_eq("addr", last_addr, e.addr);
                check_eq("err", {15'd0, err}, {15'd0, e.err});
                if (e.is_read)
                    check_eq("rdata", d_done ? d_rdata : i_rdata, e.rdata);
            end
        end
    end

    function automatic exp_t mk(input logic is_d, input logic rd, input logic [15:0] a, input logic e);
        exp_t x;
        x.is_data = is_d;
        x.is_read = rd;
        x.addr    = a;
        x.rdata   = e ? 16'h0000 : mem[a[5:0]];
        x.err     = e;
        return x;
    endfunction

    task automatic wait_for(input logic is_data, input int budget);
        int   n = 0;
        logic seen;
        do begin
            @(negedge clk);
            n++;
            seen = is_data ? d_done : i_done;
        end while (!seen && n < budget);
        check_eq("wait_bound", {15'd0, seen}, 16'd1);
    endtask

    task automatic do_fetch(input logic [15:0] a);
        i_req  = 1'b1;
        i_addr = a;
        wait_for(1'b0, 200);
        i_req = 1'b0;
    endtask

    task automatic do_data(input logic we, input logic [15:0] a, input logic [15:0] wd);
        d_req   = 1'b1;
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        wait_for(1'b1, 200);
        d_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int cnt;
        reset = 1'b1;
        i_req = 0; d_req = 0; d_we = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        inputReady = 0; ackOutput = 0; mem_drive = 0; mem_q = 0;
        mem_hang = 0; lat = 0; wait_cnt = 0; tb_drive = 0; tb_val = 0; last_addr = 0;
        for (int i = 0; i < 64; i++) mem[i] = 16'h1000 + 16'(i * 7);
        mem[5] = 16'h6303;
        mem[9] = 16'hBEEF;
        mem[0] = 16'h1111;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_readM", {15'd0, readM}, 16'd0);
        check_eq("rst_writeM", {15'd0, writeM}, 16'd0);
        check_eq("rst_done", {14'd0, i_done, d_done}, 16'd0);
        check_eq("rst_err", {15'd0, err}, 16'd0);
        check_eq("rst_address", address, 16'd0);
        check_eq("rst_i_rdata", i_rdata, 16'd0);
        check_eq("rst_d_rdata", d_rdata, 16'd0);
        tb_drive = 1'b1; tb_val = 16'hA5A5;
        #1 check_eq("rst_bus_free", data, 16'hA5A5);
        tb_drive = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Fetch read
        lat = 1;
        sb.push_back(mk(1'b0, 1'b1, 16'd5, 1'b0));
        i_req = 1'b1; i_addr = 16'd5;
        @(negedge clk);
        check_eq("fetch_readM", {15'd0, readM}, 16'd1);
        check_eq("fetch_address", address, 16'd5);
        wait_for(1'b0, 50);
        i_req = 1'b0;
        check_eq("fetch_readM_low", {15'd0, readM}, 16'd0);
        @(negedge clk);
        check_eq("fetch_done_pulse", {15'd0, i_done}, 16'd0);
        @(negedge clk);

        // Data write
        lat = 3;
        sb.push_back(mk(1'b1, 1'b0, 16'd8, 1'b0));
        d_req = 1'b1; d_we = 1'b1; d_addr = 16'd8; d_wdata = 16'h4204;
        @(negedge clk);
        n = 0;
        while (!d_done && n < 50) begin
            check_eq("wr_writeM", {15'd0, writeM}, 16'd1);
            check_eq("wr_data", data, 16'h4204);
            @(negedge clk);
            n++;
        end
        check_eq("wr_bound", {15'd0, d_done}, 16'd1);
        d_req = 1'b0;
        tb_drive = 1'b1; tb_val = 16'hA5A5;
        #1 check_eq("wr_bus_free", data, 16'hA5A5);
        tb_drive = 1'b0;
        check_eq("wr_mem", mem[8], 16'h4204);
        @(negedge clk);
        check_eq("wr_done_pulse", {15'd0, d_done}, 16'd0);
        @(negedge clk);

        // Simultaneous requests: data first, then fetch
        lat = 0;
        sb.push_back(mk(1'b1, 1'b1, 16'd9, 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 16'd0, 1'b0));
        fork
            do_data(1'b0, 16'd9, 16'd0);
            do_fetch(16'd0);
        join
        @(negedge clk);
        @(negedge clk);

        // Starvation: four data grants, then fetch, then data resumes
        for (int k = 0; k < 4; k++) sb.push_back(mk(1'b1, 1'b1, 16'(20 + k), 1'b0));
        sb.push_back(mk(1'b0, 1'b1, 16'd30, 1'b0));
        sb.push_back(mk(1'b1, 1'b1, 16'd24, 1'b0));
        sb.push_back(mk(1'b1, 1'b1, 16'd25, 1'b0));
        fork
            do_fetch(16'd30);
            begin
                d_we = 1'b0;
                for (int k = 0; k < 6; k++) begin
                    d_req  = 1'b1;
                    d_addr = 16'(20 + k);
                    wait_for(1'b1, 200);
                end
                d_req = 1'b0;
            end
        join
        @(negedge clk);
        @(negedge clk);

        // Timeout on a hung read
        mem_hang = 1'b1;
        sb.push_back(mk(1'b1, 1'b1, 16'd3, 1'b1));
        d_req = 1'b1; d_we = 1'b0; d_addr = 16'd3;
        @(negedge clk);
        n = 0; cnt = 0;
        while (!d_done && n < 100) begin
            if (readM) cnt++;
            @(negedge clk);
            n++;
        end
        d_req = 1'b0;
        check_eq("to_cycles", 16'(cnt), 16'd15);
        check_eq("to_err", {15'd0, err}, 16'd1);
        check_eq("to_rdata", d_rdata, 16'd0);
        check_eq("to_readM", {15'd0, readM}, 16'd0);
        @(negedge clk);
        check_eq("to_err_pulse", {15'd0, err}, 16'd0);
        @(negedge clk);

        // Async reset mid-read, then a clean retry
        sb.push_back(mk(1'b0, 1'b1, 16'd7, 1'b0));
        i_req = 1'b1; i_addr = 16'd7;
        @(negedge clk);
        check_eq("ar_readM", {15'd0, readM}, 16'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1 check_eq("ar_readM_drop", {15'd0, readM}, 16'd0);
        check_eq("ar_no_done", {14'd0, i_done, d_done}, 16'd0);
        @(negedge clk);
        check_eq("ar_no_done2", {14'd0, i_done, d_done}, 16'd0);
        mem_hang = 1'b0;
        reset = 1'b0;
        wait_for(1'b0, 50);
        i_req = 1'b0;
        @(negedge clk);
        @(negedge clk);

        check_eq("sb_empty", 16'(sb.size()), 16'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single CPU memory port (readM/writeM/address/data/inputReady/ackOutput) between two requesters:
  - the instruction-fetch unit;
  - the load/store data unit.
- Accepts one transaction at a time, sequences the memory strobes and handshake, and returns read data with a one-cycle completion pulse.
- Sits between the CPU datapath/control and the external memory model.

## Interface
- WORD_SIZE, 16, data/address width
- MAX_DATA_RUN, 4, consecutive data grants allowed while fetch is waiting (≥1)
- TIMEOUT_CYCLES, 15, max cycles in an access state before abort; 0 disables
- clk  in  1  clock; all sampling on rising edge
- reset  in  1  asynchronous, active-high reset
- i_req  in  1  fetch request; held with stable i_addr until i_done
- i_addr  in  WORD_SIZE  fetch address
- i_rdata  out  WORD_SIZE  fetched word, valid when i_done
- i_done  out  1  one-cycle completion pulse to fetch
- d_req  in  1  data request; held with stable d_we/d_addr/d_wdata until d_done
- d_we  in  1  1 = write, 0 = read
- d_addr  in  WORD_SIZE  data address
- d_wdata  in  WORD_SIZE  store data
- d_rdata  out  WORD_SIZE  load data, valid when d_done
- d_done  out  1  one-cycle completion pulse to data unit
- readM  out  1  memory read strobe
- writeM  out  1  memory write strobe
- address  out  WORD_SIZE  memory address
- data  inout  WORD_SIZE  memory data bus; driven only during a write, else Z
- inputReady  in  1  memory read data valid
- ackOutput  in  1  memory write accepted
- err  out  1  one-cycle pulse coincident with done when the access timed out

## Operation
- FSM states: IDLE, READ, WRITE, RELEASE.
- IDLE: arbitrate at each edge.
  - Grant data if d_req, except when i_req && run_cnt == MAX_DATA_RUN, in which case grant fetch.
  - Grant fetch if only i_req.
  - Register owner, address and write data on grant.
  - Next state is WRITE for a data grant with d_we=1, else READ.
- run_cnt:
  - increments on a data grant made while i_req=1 (saturates at MAX_DATA_RUN);
  - clears on a fetch grant, or on a data grant with i_req=0.
- READ: readM=1, address=latched addr.
  - On edge with inputReady=1: latch data into the owner's rdata, pulse owner done, go RELEASE.
- WRITE: writeM=1, data=latched wdata.
  - On edge with ackOutput=1: pulse d_done, go RELEASE.
- Timeout: a counter clears on entry to READ/WRITE and increments each cycle there.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES without a handshake: pulse owner done and err, set rdata to 0 on a read, go RELEASE.
- RELEASE: all strobes low, bus Z; requests are ignored; next state IDLE.
  - Requesters drop req in the done cycle, so no duplicate grant occurs.
- inputReady/ackOutput are ignored outside READ/WRITE respectively.
- d_req and i_req rising together in IDLE: the data unit wins, subject to the run_cnt rule.

## Timing
- Reset (async, immediate) sets:
  - state IDLE;
  - readM, writeM, i_done, d_done, err = 0;
  - address, i_rdata, d_rdata = 0;
  - data = Z;
  - run_cnt and timeout counter = 0.
- Reset mid-access drops strobes immediately; no done is issued.
- Grant at edge N (req sampled in IDLE): readM/writeM and address are high/valid after edge N.
- Handshake sampled at edge M: done/rdata are valid for the cycle after M; strobes are low after M.
- Minimum occupancy is 3 cycles per access: IDLE-grant, READ/WRITE with ready at the first edge, RELEASE.
- Back-to-back accesses from one requester are therefore ≥3 cycles apart.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Fetch read: mem[5]=16'h6303; i_req=1, i_addr=5.
  - Required: readM=1, address=5 one cycle after grant.
  - Memory answers with inputReady: i_done pulses once with i_rdata=16'h6303, then readM=0.
- Data write: d_req=1, d_we=1, d_addr=8, d_wdata=16'h4204.
  - Required: writeM=1 and data=16'h4204 until ackOutput.
  - Then a single d_done pulse, data returns to Z, mem[8]=16'h4204.
- Simultaneous requests, run_cnt=0, i_addr=0, d_addr=9 (read).
  - Required: first access is address 9 (d_done), then address 0 (i_done).
  - i_done is never asserted before d_done.
- Starvation: hold i_req=1 and re-raise d_req immediately after every d_done.
  - Required: exactly 4 data accesses complete, then one fetch access, then data resumes.
- Timeout: d_req read at addr 3; memory never asserts inputReady.
  - Required: d_done and err pulse together 15 cycles after entering READ, d_rdata=0, readM drops.
- Async reset: assert reset 1 cycle into a READ with inputReady low.
  - Required: readM=0 immediately, no i_done/d_done.
  - After release, with i_req=1 held, a fresh access at i_addr starts and completes normally.
